sprite_line_scanner: RTL
========================

// Module: sprite_line_scanner
// PURPOSE
//  Next-generation per-scanline sprite evaluator. On each line_start it scans all OAM_DEPTH OAM
//  words and collects up to MAX_PER_LINE enabled sprites that cover line_y, in OAM order.
//  Results are double-buffered: the list built during line N is published at the next line_start.
//  Sits between OAM RAM (1-cycle synchronous read) and the sprite pixel fetcher.
// PARAMETERS
//  OAM_DEPTH     64  number of OAM objects, one 32-bit word each; power of two, >=2
//  MAX_PER_LINE  8   list slots per line, 1..OAM_DEPTH
//  SPRITE_H      16  sprite height in lines; power of two, 2..64
//  (local) AW=$clog2(OAM_DEPTH), RW=$clog2(SPRITE_H), CW=$clog2(MAX_PER_LINE+1)
// PORTS
//  clk         in   1                 clock
//  reset       in   1                 reset, asynchronous, active-high
//  line_start  in   1                 1-cycle pulse: publish back list, start scan for line_y
//  line_y      in   10                line to evaluate; sampled when line_start=1
//  oam_addr    out  AW                OAM read address
//  oam_rdata   in   32                OAM word for the address presented the previous cycle
//  ent_valid   out  MAX_PER_LINE      published slot k valid
//  ent_index   out  MAX_PER_LINE*AW   OAM index of slot k (slot k at [k*AW +: AW])
//  ent_row     out  MAX_PER_LINE*RW   row in sprite for slot k, y-flip applied
//  ent_count   out  CW                number of valid published slots
//  busy        out  1                 scan in progress
//  scan_done   out  1                 1-cycle pulse when the back list is complete
//  overflow    out  1                 published list dropped >=1 sprite (macro only)
// BEHAVIOUR
//  - OAM word: [31] enable, [30] y-flip, [29] x-flip, [28] priority, [27:18] y_pos, [17:8] x_pos, [7:0] tile.
//  - Hit: enable=1 && d<SPRITE_H, d=(line_y_q-y_pos) mod 2^10 (unsigned wrap; y_pos>line_y never hits).
//  - Stored row = y-flip ? SPRITE_H-1-d[RW-1:0] : d[RW-1:0].
//  - Reset: all outputs 0; both banks cleared; FSM IDLE; oam_addr=0.
//  - FSM IDLE->SCAN on line_start; SCAN->DRAIN after address OAM_DEPTH-1 issued or back list full;
//    DRAIN (1 cycle, evaluates last returned word)->DONE; DONE->SCAN on line_start.
//  - line_start at cycle T: at edge T+1, front<=back (ent_*, ent_count, overflow update), back cleared,
//    line_y latched, oam_addr=0, busy=1. Address i is driven during cycle T+1+i; its data is evaluated
//    and written at the end of cycle T+2+i. Full scan: busy falls, scan_done pulses in cycle T+2+OAM_DEPTH.
//  - Back list full (count==MAX_PER_LINE): no further writes; without macro the scan stops issuing at once.
//  - line_start while busy: scan aborted; partial back list published as-is; new scan restarts at index 0.
//  - line_start in same cycle as final evaluation: that evaluation is included before the swap.
//  - Asynchronous reset mid-scan: immediate return to reset state; no partial list published.
//  - oam_addr holds its last value outside SCAN; no OAM reads are issued outside SCAN.
// CONFIGURATION
//  SPRITE_OVERFLOW_EN defined: after list full, scan continues to OAM_DEPTH-1; any further hit sets
//    back-overflow, published to overflow at next swap; done timing always full-scan length.
//  Undefined: scan stops when list full (early scan_done); overflow tied 0.
// STRUCTURE
//  - sprite_pkg: oam_word_t packed struct (field layout above), line_entry_t {valid,index,row},
//    OAM_Y_W=10 constant, scan_state_e enum {IDLE,SCAN,DRAIN,DONE}.
//  - Sub-module sprite_line_bank: two-bank slot storage with clear/append/swap; scanner holds FSM+compare.
// TESTING
//  1 Reset mid-scan (reset at T+5) -> all outputs 0, busy=0, no scan_done, next line_start starts clean.
//  2 OAM[3]={en=1,y=100}, line_y=107, OAM_DEPTH=64 -> next line_start: ent_count=1, ent_index[0]=3,
//    ent_row[0]=7; scan_done exactly 66 cycles after line_start.
//  3 y-flip: OAM[5]={en=1,yflip=1,y=200}, line_y=202 -> ent_row=13; y=200, line_y=216 -> no hit;
//    y=1020, line_y=4 -> no hit (no wrap-around hit).
//  4 Ten enabled hits at indices 0..9, MAX_PER_LINE=8 -> count=8, indices 0..7; with
//    SPRITE_OVERFLOW_EN overflow=1, else overflow=0 and scan_done at cycle T+10.
//  5 Disabled sprite on line (en=0) -> not listed; line_start at T+20 (abort) -> published partial
//    list holds only hits from indices 0..18.
//  6 Back-to-back lines y=10,11 with sprite y=11 -> list after line 10 empty, after 11 count=1, row 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types for the per-scanline sprite evaluator: OAM word layout, list entry, FSM states.
// Optional feature macro used by this slice: SPRITE_OVERFLOW_EN.
package sprite_pkg;

  localparam int unsigned OAM_Y_W = 10;
  localparam int unsigned OAM_X_W = 10;
  localparam int unsigned OAM_TILE_W = 8;

  // Default-geometry entry widths (64 objects, 16-line sprites)
  localparam int unsigned LE_INDEX_W = 6;
  localparam int unsigned LE_ROW_W = 4;

  typedef struct packed {
    logic                  en;
    logic                  y_flip;
    logic                  x_flip;
    logic                  prio;
    logic [OAM_Y_W-1:0]    y_pos;
    logic [OAM_X_W-1:0]    x_pos;
    logic [OAM_TILE_W-1:0] tile;
  } oam_word_t;

  typedef struct packed {
    logic                  valid;
    logic [LE_INDEX_W-1:0] index;
    logic [LE_ROW_W-1:0]   row;
  } line_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/sprite_line_scanner_if.sv
// Line-control, OAM read port and published sprite list of the scanline evaluator.
// master = scanner side, slave = environment (OAM RAM, video timing, pixel fetcher).
interface sprite_line_scanner_if #(
  parameter int unsigned OAM_DEPTH    = 64,
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned SPRITE_H     = 16
);
  localparam int unsigned AW = $clog2(OAM_DEPTH);
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned CW = $clog2(MAX_PER_LINE + 1);

  logic                       line_start;
  logic [9:0]                 line_y;
  logic [AW-1:0]              oam_addr;
  logic [31:0]                oam_rdata;
  logic [MAX_PER_LINE-1:0]    ent_valid;
  logic [MAX_PER_LINE*AW-1:0] ent_index;
  logic [MAX_PER_LINE*RW-1:0] ent_row;
  logic [CW-1:0]              ent_count;
  logic                       busy;
  logic                       scan_done;
  logic                       overflow;

  modport master (
    input  line_start, line_y, oam_rdata,
    output oam_addr, ent_valid, ent_index, ent_row, ent_count, busy, scan_done, overflow
  );

  modport slave (
    output line_start, line_y, oam_rdata,
    input  oam_addr, ent_valid, ent_index, ent_row, ent_count, busy, scan_done, overflow
  );

endinterface

// File: rtl/sprite_line_bank.sv
// Double-buffered sprite list: back list is appended during a scan, swapped to front on line_start.
// SPRITE_OVERFLOW_EN adds a back/front overflow flag; otherwise overflow is tied low.
module sprite_line_bank #(
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned AW           = 6,
  parameter int unsigned RW           = 4,
  parameter int unsigned CW           = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       swap,
  input  logic                       append,
  input  logic [AW-1:0]              app_index,
  input  logic [RW-1:0]              app_row,
  input  logic                       set_ovf,
  output logic [CW-1:0]              back_count,
  output logic                       back_full,
  output logic [MAX_PER_LINE-1:0]    ent_valid,
  output logic [MAX_PER_LINE*AW-1:0] ent_index,
  output logic [MAX_PER_LINE*RW-1:0] ent_row,
  output logic [CW-1:0]              ent_count,
  output logic                       overflow
);

  localparam int unsigned IW = MAX_PER_LINE * AW;
  localparam int unsigned TW = MAX_PER_LINE * RW;

  logic [IW-1:0]           back_idx_q, back_idx_c;
  logic [TW-1:0]           back_row_q, back_row_c;
  logic [CW-1:0]           back_cnt_q, back_cnt_c;
  logic [MAX_PER_LINE-1:0] back_vld_c;

  assign back_count = back_cnt_q;
  assign back_full  = (back_cnt_q == CW'(MAX_PER_LINE));

  // Back list including this cycle's append, so a swap never loses the word being evaluated
  always_comb begin
    back_idx_c = back_idx_q;
    back_row_c = back_row_q;
    back_cnt_c = back_cnt_q;
    back_vld_c = '0;
    if (append && !back_full) begin
      for (int k = 0; k < int'(MAX_PER_LINE); k++) begin
        if (back_cnt_q == CW'(k)) begin
          back_idx_c[k*AW +: AW] = app_index;
          back_row_c[k*RW +: RW] = app_row;
        end
      end
      back_cnt_c = back_cnt_q + CW'(1);
    end
    for (int k = 0; k < int'(MAX_PER_LINE); k++) begin
      back_vld_c[k] = (CW'(k) < back_cnt_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      back_idx_q <= '0;
      back_row_q <= '0;
      back_cnt_q <= '0;
      ent_valid  <= '0;
      ent_index  <= '0;
      ent_row    <= '0;
      ent_count  <= '0;
    end else if (swap) begin
      ent_valid  <= back_vld_c;
      ent_index  <= back_idx_c;
      ent_row    <= back_row_c;
      ent_count  <= back_cnt_c;
      back_idx_q <= '0;
      back_row_q <= '0;
      back_cnt_q <= '0;
    end else begin
      back_idx_q <= back_idx_c;
      back_row_q <= back_row_c;
      back_cnt_q <= back_cnt_c;
    end
  end

`ifdef SPRITE_OVERFLOW_EN
  logic back_ovf_q;
  logic back_ovf_c;

  assign back_ovf_c = back_ovf_q | set_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      back_ovf_q <= 1'b0;
      overflow   <= 1'b0;
    end else if (swap) begin
      overflow   <= back_ovf_c;
      back_ovf_q <= 1'b0;
    end else begin
      back_ovf_q <= back_ovf_c;
    end
  end
`else
  logic unused_set_ovf;

  assign unused_set_ovf = set_ovf;
  assign overflow       = 1'b0;
`endif

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite evaluator: scans OAM on line_start and builds the next line's sprite list.
// SPRITE_OVERFLOW_EN: keep scanning past a full list and flag any dropped hit as overflow.
module sprite_line_scanner
  import sprite_pkg::*;
#(
  parameter int unsigned OAM_DEPTH    = 64,
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned SPRITE_H     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_line_scanner_if.master bus
);

  localparam int unsigned AW = $clog2(OAM_DEPTH);
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned CW = $clog2(MAX_PER_LINE + 1);

`ifdef SPRITE_OVERFLOW_EN
  localparam bit STOP_ON_FULL = 1'b0;
`else
  localparam bit STOP_ON_FULL = 1'b1;
`endif

  scan_state_e        state_q, state_d;
  logic [OAM_Y_W-1:0] line_y_q;
  logic [AW-1:0]      addr_q, addr_d;
  logic               rd_vld_q, rd_vld_d;
  logic [AW-1:0]      rd_idx_q;
  logic               busy_q;
  logic               done_q;

  oam_word_t          word_c;
  logic [OAM_Y_W:0]   diff_c;
  logic               hit_c;
  logic [RW-1:0]      row_c;
  logic               eval_c;
  logic               append_c;
  logic               fill_c;
  logic               set_ovf_c;
  logic [CW-1:0]      back_count;
  logic               back_full;
  logic               unused_fields;

  // Hit test on the word returned for the address issued last cycle; borrow rejects y_pos > line_y
  assign word_c   = oam_word_t'(bus.oam_rdata);
  assign diff_c   = {1'b0, line_y_q} - {1'b0, word_c.y_pos};
  assign hit_c    = word_c.en && !diff_c[OAM_Y_W] &&
                    (diff_c[OAM_Y_W-1:0] < OAM_Y_W'(SPRITE_H));
  assign row_c    = word_c.y_flip ? (RW'(SPRITE_H - 1) - diff_c[RW-1:0]) : diff_c[RW-1:0];

  assign eval_c    = rd_vld_q && ((state_q == SCAN) || (state_q == DRAIN));
  assign append_c  = eval_c && hit_c && !back_full;
  assign fill_c    = append_c && (back_count == CW'(MAX_PER_LINE - 1));
  assign set_ovf_c = !STOP_ON_FULL && eval_c && hit_c && back_full;

  assign unused_fields = ^{word_c.x_flip, word_c.prio, word_c.x_pos, word_c.tile};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_vld_d = 1'b0;
    unique case (state_q)
      IDLE: ;
      SCAN: begin
        rd_vld_d = 1'b1;
        if (STOP_ON_FULL && fill_c) begin
          state_d = DONE;
        end else if (addr_q == AW'(OAM_DEPTH - 1)) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    ;
      default: state_d = IDLE;
    endcase
    // line_start from any state publishes and restarts; in-flight read is discarded
    if (bus.line_start) begin
      state_d  = SCAN;
      addr_d   = '0;
      rd_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      line_y_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= addr_q;
      if (bus.line_start) begin
        line_y_q <= bus.line_y;
      end
      busy_q   <= (state_d == SCAN) || (state_d == DRAIN);
      done_q   <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign bus.oam_addr  = addr_q;
  assign bus.busy      = busy_q;
  assign bus.scan_done = done_q;

  sprite_line_bank #(
    .MAX_PER_LINE (MAX_PER_LINE),
    .AW           (AW),
    .RW           (RW),
    .CW           (CW)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .swap       (bus.line_start),
    .append     (append_c),
    .app_index  (rd_idx_q),
    .app_row    (row_c),
    .set_ovf    (set_ovf_c),
    .back_count (back_count),
    .back_full  (back_full),
    .ent_valid  (bus.ent_valid),
    .ent_index  (bus.ent_index),
    .ent_row    (bus.ent_row),
    .ent_count  (bus.ent_count),
    .overflow   (bus.overflow)
  );

endmodule
